// File: rtl/ps2_keyboard_tracker_if.sv
// ps2_keyboard_tracker_if: key status bundle from the PS/2 tracker to the Game-of-Life control logic.
interface ps2_keyboard_tracker_if;
    logic s;
    logic r;
    logic d;
    logic enter;
    logic space;
    modport master (output s, r, d, enter, space);
    modport slave  (input  s, r, d, enter, space);
endinterface

// File: rtl/ps2_keyboard_tracker.sv
// ps2_keyboard_tracker: receive-only PS/2 scan-code set 2 decoder tracking S, R, D, Enter and Space.
module ps2_keyboard_tracker #(
    parameter int PULSE_OR_HOLD  = 0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    inout  wire                    PS2_CLK,
    inout  wire                    PS2_DAT,
    ps2_keyboard_tracker_if.master keys
);
    localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      EXT    = 8'hE0;
    localparam logic [7:0]      BRK    = 8'hF0;

    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic          clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [4:0]    pressed_q, pressed_d, out_q, out_d;
    logic          fall, frame_done, frame_ok, timeout_hit, apply;
    logic [4:0]    key_sel;

    always_comb begin
        fall         = clk_prev_q & ~clk_sync_q;
        frame_done   = fall && bit_cnt_q == 4'd10;
        frame_ok     = ~shift_q[0] & dat_sync_q & (^shift_q[9:1]);
        timeout_hit  = !fall && bit_cnt_q != 4'd0 && to_q == TO_MAX;
        bit_cnt_d    = fall ? (frame_done ? 4'd0 : bit_cnt_q + 4'd1) : (timeout_hit ? 4'd0 : bit_cnt_q);
        to_d         = (fall || timeout_hit || bit_cnt_q == 4'd0) ? '0 : to_q + 1'b1;
        shift_d      = fall ? {dat_sync_q, shift_q[9:1]} : shift_q;
        byte_valid_d = frame_done & frame_ok;
        byte_d       = frame_done ? shift_q[8:1] : byte_q;
        key_sel      = {byte_q == 8'h1B, byte_q == 8'h2D, byte_q == 8'h23, byte_q == 8'h5A, byte_q == 8'h29};
        // Prefix bytes only arm flags; any other byte consumes them, extended keys are never tracked.
        apply        = byte_valid_q && byte_q != EXT && byte_q != BRK && !ext_q;
        pressed_d    = !apply ? pressed_q : (brk_q ? pressed_q & ~key_sel : pressed_q | key_sel);
        ext_d        = (frame_done && !frame_ok) ? 1'b0 :
                       byte_valid_q ? (byte_q == EXT ? 1'b1 : byte_q == BRK ? ext_q : 1'b0) : ext_q;
        brk_d        = (frame_done && !frame_ok) ? 1'b0 :
                       byte_valid_q ? (byte_q == BRK ? 1'b1 : byte_q == EXT ? brk_q : 1'b0) : brk_q;
        out_d        = (PULSE_OR_HOLD != 0) ? pressed_d & ~pressed_q : pressed_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            to_q         <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            pressed_q    <= '0;
            out_q        <= '0;
        end else begin
            clk_meta_q   <= PS2_CLK;
            clk_sync_q   <= clk_meta_q;
            clk_prev_q   <= clk_sync_q;
            dat_meta_q   <= PS2_DAT;
            dat_sync_q   <= dat_meta_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_q         <= to_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            pressed_q    <= pressed_d;
            out_q        <= out_d;
        end
    end

    assign keys.s     = out_q[4];
    assign keys.r     = out_q[3];
    assign keys.d     = out_q[2];
    assign keys.enter = out_q[1];
    assign keys.space = out_q[0];
endmodule

// File: tb/tb_ps2_keyboard_tracker.sv
// tb_ps2_keyboard_tracker: hold- and pulse-mode trackers on one PS/2 bus, compared every cycle with a frame-level model.
module tb_ps2_keyboard_tracker;
    localparam int HALF = 8;
    localparam int TO   = 200;
    localparam int LONG = 3 * TO;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic clk_drv = 1'b1;
    logic dat_drv = 1'b1;
    wire  ps2_clk;
    wire  ps2_dat;
    assign ps2_clk = clk_drv;
    assign ps2_dat = dat_drv;

    always #5 clock = ~clock;

    ps2_keyboard_tracker_if kh ();
    ps2_keyboard_tracker_if kp ();

    ps2_keyboard_tracker #(.PULSE_OR_HOLD(0), .TIMEOUT_CYCLES(TO)) dut_hold (
        .clock(clock), .reset_n(reset_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .keys(kh));
    ps2_keyboard_tracker #(.PULSE_OR_HOLD(1), .TIMEOUT_CYCLES(TO)) dut_pulse (
        .clock(clock), .reset_n(reset_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .keys(kp));

    int errors = 0;
    int checks = 0;
    logic       mon_en = 1'b0;
    logic [4:0] exp_hold = '0, exp_pulse = '0;
    logic [4:0] m_pressed = '0;
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [10:0] fbits = '0;
    int         nbits = 0;
    logic [7:0] codes [5] = '{8'h1B, 8'h2D, 8'h23, 8'h5A, 8'h29};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) if (mon_en) begin
        chk("hold_keys",  {3'b0, kh.s, kh.r, kh.d, kh.enter, kh.space}, {3'b0, exp_hold});
        chk("pulse_keys", {3'b0, kp.s, kp.r, kp.d, kp.enter, kp.space}, {3'b0, exp_pulse});
        chk("bus_released", {6'b0, ps2_clk, ps2_dat}, {6'b0, clk_drv, dat_drv});
    end

    // Model: gather 11 sampled bits into a frame, then apply scan-code rules to a pressed-key set.
    task automatic model_bit(input logic b);
        logic [7:0] code;
        logic [4:0] old;
        fbits[nbits] = b;
        nbits++;
        if (nbits == 11) begin
            nbits = 0;
            code = fbits[8:1];
            old = m_pressed;
            if (fbits[0] != 1'b0 || fbits[10] != 1'b1 || (^fbits[9:1]) != 1'b1) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (code == 8'hE0) m_ext = 1'b1;
            else if (code == 8'hF0) m_brk = 1'b1;
            else begin
                if (!m_ext)
                    for (int k = 0; k < 5; k++)
                        if (codes[k] == code) m_pressed[4-k] = !m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
            exp_hold = m_pressed;
            exp_pulse = m_pressed & ~old;
        end
    endtask

    task automatic send_bit(input logic b);
        dat_drv = b;
        repeat (HALF) @(posedge clock);
        #1 clk_drv = 1'b0;
        repeat (4) @(posedge clock);
        model_bit(b);
        @(posedge clock);
        exp_pulse = '0;
        repeat (HALF - 5) @(posedge clock);
        #1 clk_drv = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] c, input logic bad);
        return {1'b1, ~(^c) ^ bad, c, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] c);
        send_bits(mk_frame(c, 1'b0), 11);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
        if (n >= TO) nbits = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        nbits = 0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_pressed = '0;
        exp_hold = '0;
        exp_pulse = '0;
        #1 reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        mon_en = 1'b1;
        #1 reset_n = 1'b1;
        idle(4);
        send_byte(8'h1B);
        chk("s_make", {7'b0, kh.s}, 8'd1);
        send_byte(8'hF0); send_byte(8'h1B);
        chk("s_break", {7'b0, kh.s}, 8'd0);
        send_byte(8'h5A);
        chk("enter_make", {7'b0, kh.enter}, 8'd1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
        chk("enter_ext_break", {7'b0, kh.enter}, 8'd1);
        send_byte(8'hF0); send_byte(8'h5A);
        chk("enter_break", {7'b0, kh.enter}, 8'd0);
        send_byte(8'hE0); send_byte(8'h5A);
        chk("keypad_enter", {7'b0, kh.enter}, 8'd0);
        send_bits(mk_frame(8'h29, 1'b1), 11);
        chk("space_bad_par", {7'b0, kh.space}, 8'd0);
        send_byte(8'h29);
        chk("space_make", {7'b0, kh.space}, 8'd1);
        repeat (3) send_byte(8'h23);
        send_byte(8'hF0); send_byte(8'h23);
        send_byte(8'h23);
        chk("d_hold", {7'b0, kh.d}, 8'd1);
        send_bits(mk_frame(8'h2D, 1'b0), 6);
        idle(LONG);
        send_byte(8'h2D);
        chk("r_after_timeout", {7'b0, kh.r}, 8'd1);
        send_byte(8'hF0); send_byte(8'h2D);
        send_bits(mk_frame(8'h2D, 1'b0), 6);
        send_byte(8'h2D);
        chk("r_misaligned", {7'b0, kh.r}, 8'd0);
        idle(LONG);
        send_byte(8'h1B);
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        do_reset();
        chk("reset_space", {7'b0, kh.space}, 8'd0);
        send_byte(8'h1B);
        chk("s_after_reset", {7'b0, kh.s}, 8'd1);
        for (int n = 0; n < 60; n++) begin
            int sel;
            logic [7:0] c;
            sel = int'($urandom_range(0, 9));
            c = (sel < 5) ? codes[sel] : (sel == 5) ? 8'hE0 : (sel < 8) ? 8'hF0 : 8'($urandom);
            case ($urandom_range(0, 11))
                0: begin send_bits(mk_frame(c, 1'b0), int'($urandom_range(1, 10))); idle(LONG); end
                1: send_bits(mk_frame(c, 1'b1), 11);
                2: send_bits(mk_frame(c, 1'b0), int'($urandom_range(1, 10)));
                default: send_byte(c);
            endcase
            idle(int'($urandom_range(0, 20)));
        end
        idle(LONG);
        send_byte(8'h29);
        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_tracker.md
Name: ps2_keyboard_tracker

Overview:
- Receive-only PS/2 keyboard decoder for the Game-of-Life top level.
- Deserialises PS/2 device-to-host frames and decodes scan-code set 2 make/break sequences.
- Exposes per-key status for S, R, D, Enter and Space, which the control FSM and rate divider consume.
- Never drives the PS/2 bus.

Parameters:
- PULSE_OR_HOLD, 0, output mode: 0 = hold (level high while key held), 1 = pulse (one-cycle pulse per press).
- TIMEOUT_CYCLES, 50000, clock cycles without a PS2_CLK falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous, active-low reset.
- PS2_CLK  inout  1  PS/2 clock; always released (high-Z); read only.
- PS2_DAT  inout  1  PS/2 data; always released (high-Z); read only.
- s  output  1  S key status (scan 0x1B).
- r  output  1  R key status (0x2D).
- d  output  1  D key status (0x23).
- enter  output  1  main Enter status (0x5A, non-extended only).
- space  output  1  Space status (0x29).

Behaviour:
- Reset: reset_n low at a clock edge clears all outputs to 0, bit counter, shift register, break/extended flags, pressed state, timeout counter. Applies mid-frame; the partial frame is discarded.
- Synchronisation: PS2_CLK and PS2_DAT each pass through 2 flops. A falling edge is detected when the synced clock is 0 and its previous value was 1. PS2_DAT (synced) is sampled on that cycle.
- Frame: 11 bits = start 0, 8 data LSB first, odd parity, stop 1. A 4-bit counter counts 0..10.
- Sampling the stop bit completes the frame.
  - Valid frame: start==0, stop==1, XOR of data+parity==1. It produces a byte_valid strobe the next cycle.
  - Invalid frame: the byte is dropped and the break/extended flags are cleared.
  - Either way the counter returns to 0.
- Timeout: the counter increments each cycle while the bit count is nonzero and no edge occurs. At TIMEOUT_CYCLES the bit count resets to 0 and the flags are unaffected.
- Decoder, per valid byte:
  - 0xE0 sets the extended flag.
  - 0xF0 sets the break flag.
  - Any other byte is a key code, applied using the current flags; then both flags clear.
  - Extended codes (E0-prefixed) never affect outputs, so keypad Enter (E0 5A) is ignored.
  - Unlisted codes are ignored.
- Pressed state per key: make sets it, break clears it. A break for an unpressed key has no effect. Keys are independent; multiple keys may be held simultaneously.
- Hold mode (PULSE_OR_HOLD=0): output = pressed state. Typematic repeat makes keep it at 1.
- Pulse mode (PULSE_OR_HOLD=1): output is 1 for exactly one cycle when pressed state goes 0->1. Repeat makes while held produce no further pulse. A break produces no pulse.
- Latency: the output changes exactly 2 clock cycles after the cycle the stop-bit falling edge is detected (byte_valid cycle + decode register). Total from the raw PS2_CLK pin edge is 4 cycles.
- PS2_CLK and PS2_DAT are never driven (assigned 1'bz).

Test Plan:
- Reset then send make 0x1B at 10 kHz PS/2 clock (PULSE_OR_HOLD=0) -> s=1 two cycles after the stop-bit edge is detected; r, d, enter, space stay 0. Then send F0 1B -> s=0.
- Send 0x5A, then E0 F0 5A, then F0 5A (hold mode) -> enter=1 after 0x5A; still 1 after the extended break; 0 after F0 5A. Separately, E0 5A from idle leaves enter=0.
- Frame with bad parity carrying 0x29 -> space stays 0; the next valid 0x29 sets space=1.
- PULSE_OR_HOLD=1: send 0x23 three times (typematic), then F0 23, then 0x23 -> d is high for exactly one cycle after the first make, none on repeats or the break, and one pulse after the final make.
- Send 6 bits of a frame, idle > TIMEOUT_CYCLES, then a full 0x2D frame -> r=1. Without the idle gap the misaligned data yields no r assertion.
- Assert reset_n=0 for one cycle while s and space are held and mid-frame -> all outputs 0 next cycle. A subsequent full 0x1B frame decodes correctly (s=1).
